// File: rtl/mod_cntr_pkg.sv
// Shared constants for the modulus counter family: direction and mode
// encodings plus default parameter values.
package mod_cntr_pkg;

   // Direction encodings for the dir input
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Mode encodings for the oneshot input
   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Default widths
   localparam int WIDTH_DEF   = 8;
   localparam int PRESC_W_DEF = 4;

endpackage : mod_cntr_pkg

// File: rtl/mod_cntr_gen_if.sv
// Control/status bundle of mod_cntr_gen. The master drives the level
// controls; the slave (the counter) returns cnt/tc/done.
// There is no handshake: every control is a plain level that is sampled
// on each rising clock edge, and the outputs are registered.
// Optional feature macro: MOD_CNTR_PRESCALE_EN adds the presc field.
interface mod_cntr_gen_if
   import mod_cntr_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
`ifdef MOD_CNTR_PRESCALE_EN
   ,parameter int PRESC_W = PRESC_W_DEF
`endif
);

   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] modulus;
   logic             dir;
   logic             oneshot;
`ifdef MOD_CNTR_PRESCALE_EN
   logic [PRESC_W-1:0] presc;
`endif
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             done;

   modport master (
      output en, clr, load, load_val, modulus, dir, oneshot,
`ifdef MOD_CNTR_PRESCALE_EN
      output presc,
`endif
      input  cnt, tc, done
   );

   modport slave (
      input  en, clr, load, load_val, modulus, dir, oneshot,
`ifdef MOD_CNTR_PRESCALE_EN
      input  presc,
`endif
      output cnt, tc, done
   );

endinterface : mod_cntr_gen_if

// File: rtl/cntr_prescaler.sv
// Enable prescaler for mod_cntr_gen: counts en cycles 0..presc and emits
// tick on the en cycle where the count has reached presc.
// Only built when MOD_CNTR_PRESCALE_EN is defined.
`ifdef MOD_CNTR_PRESCALE_EN
module cntr_prescaler
   import mod_cntr_pkg::*;
#(
   parameter int PRESC_W = PRESC_W_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic               sclr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic               wrap;

   // Next prescaler count: clear dominates, hold while en is low, and a
   // count at or beyond presc (presc lowered at runtime) wraps to zero.
   always_comb begin
      wrap   = (pcnt_q >= presc);
      pcnt_d = pcnt_q;
      if (sclr) begin
         pcnt_d = '0;
      end else if (en) begin
         pcnt_d = wrap ? '0 : (pcnt_q + P_ONE);
      end
   end

   assign tick = en & wrap;

   // Prescaler count register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule : cntr_prescaler
`endif

// File: rtl/mod_cntr_gen.sv
// Runtime-programmable modulus counter: up/down, periodic or one-shot,
// synchronous clear/load, registered terminal-count pulse and done level.
// Optional feature macro: MOD_CNTR_PRESCALE_EN inserts cntr_prescaler so
// that steps happen only every presc+1 enabled cycles.
module mod_cntr_gen
   import mod_cntr_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
`ifdef MOD_CNTR_PRESCALE_EN
   ,parameter int PRESC_W = PRESC_W_DEF
`endif
) (
   input  logic           clk,
   input  logic           rstn,
   mod_cntr_gen_if.slave  bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             tick;
   logic [WIDTH:0]   step_r;

   // Result of one step as {terminal, next_count}. cnt >= M counts as
   // terminal going up, so lowering M below cnt ends the cycle at once.
   function automatic logic [WIDTH:0] step_next(
      input logic [WIDTH-1:0] c,
      input logic [WIDTH-1:0] m,
      input logic             d,
      input logic             os
   );
      logic [WIDTH-1:0] nxt;
      logic             term;
      nxt  = c;
      term = 1'b0;
      case (d)
         DIR_UP: begin
            if (c < m) begin
               nxt = c + ONE;
            end else begin
               term = 1'b1;
               nxt  = (os == MODE_PERIODIC) ? '0 : c;
            end
         end
         DIR_DOWN: begin
            if (c != '0) begin
               nxt = c - ONE;
            end else begin
               term = 1'b1;
               nxt  = (os == MODE_PERIODIC) ? m : c;
            end
         end
      endcase
      return {term, nxt};
   endfunction

`ifdef MOD_CNTR_PRESCALE_EN
   cntr_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk   (clk),
      .rstn  (rstn),
      .en    (bus.en),
      .sclr  (bus.clr | bus.load),
      .presc (bus.presc),
      .tick  (tick)
   );
`else
   assign tick = bus.en;
`endif

   // Next-state for count/tc/done with priority clr > load > step > hold
   always_comb begin
      step_r = step_next(cnt_q, bus.modulus, bus.dir, bus.oneshot);
      cnt_d  = cnt_q;
      tc_d   = 1'b0;
      done_d = done_q;
      if (bus.clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (bus.load) begin
         cnt_d  = bus.load_val;
         done_d = 1'b0;
      end else if (tick && !done_q) begin
         cnt_d = step_r[WIDTH-1:0];
         tc_d  = step_r[WIDTH];
         if (step_r[WIDTH] && (bus.oneshot == MODE_ONESHOT)) begin
            done_d = 1'b1;
         end
      end
   end

   // Counter state registers, asynchronously cleared
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q  <= '0;
         tc_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tc_q   <= tc_d;
         done_q <= done_d;
      end
   end

   assign bus.cnt  = cnt_q;
   assign bus.tc   = tc_q;
   assign bus.done = done_q;

endmodule : mod_cntr_gen

// File: doc/mod_cntr_gen.md
# mod_cntr_gen

Parametrised, runtime-programmable modulus counter. It generalises the fixed mod-N counter with:
- a configurable width and a modulus supplied at runtime
- up/down counting, synchronous clear and load
- one-shot or periodic mode, with a terminal-count pulse
- an optional compile-time prescaler

It serves as the timing/sequencing primitive behind the APB slaves: timers, wait-state generators and watchdog-style counters.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRESC_W, 4, prescaler width; used only when the prescaler is compiled in
- clk  input  1  clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- en  input  1  count enable; a step occurs only on en-qualified ticks
- clr  input  1  synchronous clear
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value loaded into cnt
- modulus  input  WIDTH  terminal value M; count range is 0..M, period M+1
- dir  input  1  1 = count up, 0 = count down
- oneshot  input  1  1 = stop at terminal, 0 = periodic wrap
- presc  input  PRESC_W  prescale divisor minus 1 (present only with the macro)
- cnt  output  WIDTH  current count
- tc  output  1  terminal-count pulse, one cycle
- done  output  1  one-shot finished, level

## Operation
- Reset: cnt=0, tc=0, done=0, prescaler count=0.
- Per-edge priority: clr > load > step > hold.
- clr: cnt←0, done←0, prescaler←0, tc←0.
- load: cnt←load_val, done←0, prescaler←0, tc←0. load_val > modulus is accepted unchanged.
- A step occurs when tick=1 and done=0. tick = en without the macro (see Configuration for the prescaled case).
- Up step:
  - cnt<M → cnt+1.
  - cnt≥M is terminal: periodic → cnt←0; one-shot → cnt holds, done←1.
  - Terminal covers M lowered below the current cnt at runtime.
- Down step:
  - cnt≠0 → cnt−1.
  - cnt=0 is terminal: periodic → cnt←M; one-shot → cnt holds at 0, done←1.
- tc is registered. It is 1 for exactly the one cycle following each terminal step, and 0 otherwise.
- done=1 blocks all steps. Only clr, load or rstn clear it.
- M=0: every step is terminal. Periodic mode gives tc on every step with cnt staying 0.
- modulus, dir and oneshot are sampled on every step; changes take effect on the next step.
- Arithmetic is WIDTH-bit unsigned. No wrap occurs other than the terminal rules above.

## Timing
- One step per tick. cnt and tc update on the same rising edge, so there is no extra latency.
- clr/load take effect on the edge where they are sampled high. They override a coincident step, and that step produces no tc.
- rstn assertion clears all state immediately (asynchronous). Deassertion is synchronised externally. After release, the first step may occur on the first edge.

## Configuration
- MOD_CNTR_PRESCALE_EN defined:
  - The presc port and a PRESC_W prescaler counter exist.
  - The prescaler counts en cycles 0..presc; tick=1 on the en cycle where prescaler==presc, then the prescaler returns to 0.
  - presc=0 → tick=en.
  - The prescaler holds while en=0, and clears on clr/load/rstn.
- Not defined: no presc port, no prescaler, tick=en.

## Structure
- Shared package mod_cntr_pkg holds:
  - direction constants DIR_UP=1, DIR_DOWN=0
  - mode constants MODE_PERIODIC=0, MODE_ONESHOT=1
  - default widths
- One natural sub-module: cntr_prescaler, instantiated only under MOD_CNTR_PRESCALE_EN, outputting tick.

## Test plan
- WIDTH=5, M=4, up, periodic, en=1 → cnt 0,1,2,3,4,0,1…; tc high only in cycles where cnt returns to 0 (every 5th).
- load_val=2, M=3, down, periodic → cnt 2,1,0,3,2; tc high with cnt=3 only.
- M=2, up, oneshot → cnt 0,1,2,2,2…; done=1 from the cycle after cnt reaches 2; a single tc pulse; a subsequent load 0 restarts counting.
- cnt=7, M changed to 3 (up) → next step cnt=0 with tc; clr and load asserted together → cnt=0, no tc.
- With the macro, presc=2, en=1 → cnt advances every 3rd cycle; en=0 for 2 cycles mid-phase stretches the period by 2.
- rstn asserted while cnt=3, done=1 → cnt=0, tc=0, done=0 immediately; counting resumes from 0 after release.
